// File: rtl/ram_pkg.sv
// Shared definitions for the byte-enabled RAM family: collision-mode encodings and
// the lane-merge helper also used by the cache blocks.
package ram_pkg;

    localparam int unsigned RDW_OLD = 0;
    localparam int unsigned RDW_NEW = 1;

    // Widest word and lane count the merge helper handles; callers zero-extend and truncate.
    localparam int unsigned MERGE_MAX_W = 256;

    typedef logic [MERGE_MAX_W-1:0] merge_word_t;
    typedef logic [MERGE_MAX_W-1:0] merge_be_t;

    function automatic merge_word_t be_merge(
        input merge_word_t old_word,
        input merge_word_t new_word,
        input merge_be_t   be,
        input int unsigned byte_w
    );
        merge_word_t w_res;
        int unsigned lane_w;
        lane_w = (byte_w == 0) ? 1 : byte_w;
        for (int unsigned i = 0; i < MERGE_MAX_W; i++) begin
            w_res[i] = be[8'(i / lane_w)] ? new_word[i] : old_word[i];
        end
        return w_res;
    endfunction

endpackage

// File: rtl/ram_byte_lane.sv
// One byte lane of the RAM: a BYTE_W x 2**DEPTH array with one write enable and a
// registered read port (read-first on same-address access).
module ram_byte_lane
    import ram_pkg::*;
#(
    parameter int unsigned BYTE_W = 8,
    parameter int unsigned DEPTH  = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [DEPTH-1:0]  i_wr_addr,
    input  logic [BYTE_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [DEPTH-1:0]  i_rd_addr,
    output logic [BYTE_W-1:0] o_rd_data
);

    logic [BYTE_W-1:0] r_mem [2**DEPTH];
    logic [BYTE_W-1:0] r_rd_q;

    // Array has no reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_q <= '0;
        end else if (i_rd_en) begin
            r_rd_q <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_q;

endmodule

// File: rtl/ram_sdp_be.sv
// Simple dual-port RAM with per-byte write enables, 1- or 2-cycle read latency,
// read-valid strobe and selectable read-during-write collision behaviour.
module ram_sdp_be
    import ram_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 10,
    parameter int unsigned BYTE_W   = 8,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned RDW_MODE = RDW_OLD
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_wr_en,
    input  logic [DEPTH-1:0]          i_wr_addr,
    input  logic [WIDTH/BYTE_W-1:0]   i_wr_be,
    input  logic [WIDTH-1:0]          i_wr_data,
    input  logic                      i_rd_en,
    input  logic [DEPTH-1:0]          i_rd_addr,
    output logic [WIDTH-1:0]          o_rd_data,
    output logic                      o_rd_valid
);

    localparam int unsigned NBE = WIDTH / BYTE_W;

    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
        $error("ram_sdp_be: RD_LAT must be 1 or 2");
    end
    if (NBE * BYTE_W != WIDTH) begin : g_bad_width
        $error("ram_sdp_be: WIDTH must be a multiple of BYTE_W");
    end

    logic             w_wr_en;
    logic             w_rd_en;
    logic [WIDTH-1:0] w_lane_q;

    assign w_wr_en = i_wr_en & i_rst_n;
    assign w_rd_en = i_rd_en & i_rst_n;

    for (genvar g = 0; g < NBE; g++) begin : g_lane
        ram_byte_lane #(
            .BYTE_W (BYTE_W),
            .DEPTH  (DEPTH)
        ) u_lane (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_wr_en   (w_wr_en & i_wr_be[g]),
            .i_wr_addr (i_wr_addr),
            .i_wr_data (i_wr_data[g*BYTE_W +: BYTE_W]),
            .i_rd_en   (w_rd_en),
            .i_rd_addr (i_rd_addr),
            .o_rd_data (w_lane_q[g*BYTE_W +: BYTE_W])
        );
    end

    // Lanes are read-first; write-first is built by merging the captured write over the old word.
    logic             w_coll;
    logic             r_coll;
    logic [WIDTH-1:0] r_byp_data;
    logic [NBE-1:0]   r_byp_be;

    assign w_coll = (RDW_MODE == RDW_NEW) && w_wr_en && (i_wr_addr == i_rd_addr);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_coll     <= 1'b0;
            r_byp_data <= '0;
            r_byp_be   <= '0;
        end else if (w_rd_en) begin
            r_coll     <= w_coll;
            r_byp_data <= i_wr_data;
            r_byp_be   <= i_wr_be;
        end
    end

    merge_word_t      w_merged_full;
    logic [WIDTH-1:0] w_rd_data1;
    logic             w_unused_merge;

    assign w_merged_full  = be_merge(merge_word_t'(w_lane_q), merge_word_t'(r_byp_data),
                                     merge_be_t'(r_byp_be), BYTE_W);
    assign w_unused_merge = ^w_merged_full[MERGE_MAX_W-1:WIDTH];
    assign w_rd_data1     = r_coll ? w_merged_full[WIDTH-1:0] : w_lane_q;

    logic r_vld1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld1 <= 1'b0;
        end else begin
            r_vld1 <= w_rd_en;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic             r_vld2;
        logic [WIDTH-1:0] r_rd_data2;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_vld2     <= 1'b0;
                r_rd_data2 <= '0;
            end else begin
                r_vld2 <= r_vld1;
                if (r_vld1) begin
                    r_rd_data2 <= w_rd_data1;
                end
            end
        end

        assign o_rd_data  = r_rd_data2;
        assign o_rd_valid = r_vld2;
    end else begin : g_lat1
        assign o_rd_data  = w_rd_data1;
        assign o_rd_valid = r_vld1;
    end

endmodule

// File: tb/tb_ram_sdp_be.sv
// Scoreboard bench: one RAM in read-first/latency-1 form, one in write-first/latency-2
// form, driven with identical traffic and checked against a word-level memory model.
module tb_ram_sdp_be;
    import ram_pkg::*;

    localparam int unsigned W   = 32;
    localparam int unsigned D   = 10;
    localparam int unsigned NBE = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           wr_en = 1'b0;
    logic [D-1:0]   wr_addr = '0;
    logic [NBE-1:0] wr_be = '0;
    logic [W-1:0]   wr_data = '0;
    logic           rd_en = 1'b0;
    logic [D-1:0]   rd_addr = '0;
    logic [W-1:0]   rd_data_a, rd_data_b;
    logic           rd_valid_a, rd_valid_b;

    always #5 clk = ~clk;

    ram_sdp_be #(.WIDTH(W), .DEPTH(D), .BYTE_W(8), .RD_LAT(1), .RDW_MODE(RDW_OLD)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_be(wr_be),
        .i_wr_data(wr_data), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_data(rd_data_a), .o_rd_valid(rd_valid_a)
    );

    ram_sdp_be #(.WIDTH(W), .DEPTH(D), .BYTE_W(8), .RD_LAT(2), .RDW_MODE(RDW_NEW)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_be(wr_be),
        .i_wr_data(wr_data), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_data(rd_data_b), .o_rd_valid(rd_valid_b)
    );

    typedef struct packed {
        int           due;
        logic [W-1:0] data;
    } exp_t;

    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;
    exp_t         q_a[$];
    exp_t         q_b[$];
    logic [W-1:0] mem_m [2**D];
    logic [W-1:0] last_a = '0;
    logic [W-1:0] last_b = '0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] lane_write(input logic [W-1:0] old_w,
                                                input logic [W-1:0] new_w,
                                                input logic [NBE-1:0] be);
        logic [W-1:0] res;
        res = old_w;
        for (int l = 0; l < NBE; l++) begin
            if (be[l]) res[l*8 +: 8] = new_w[l*8 +: 8];
        end
        return res;
    endfunction

    // Drive one cycle of traffic; expectations are queued against the edge that samples it.
    task automatic op(input logic we, input int wa, input logic [NBE-1:0] be,
                      input logic [W-1:0] wd, input logic re, input int ra);
        exp_t e;
        @(negedge clk);
        wr_en   = we;
        wr_addr = wa[D-1:0];
        wr_be   = be;
        wr_data = wd;
        rd_en   = re;
        rd_addr = ra[D-1:0];
        if (rst_n && re) begin
            e.due  = cyc + 1;
            e.data = mem_m[ra];
            q_a.push_back(e);
            e.due = cyc + 2;
            if (we && wa == ra) e.data = lane_write(mem_m[ra], wd, be);
            q_b.push_back(e);
        end
        if (rst_n && we) mem_m[wa] = lane_write(mem_m[wa], wd, be);
    endtask

    task automatic idle(input int n);
        repeat (n) op(1'b0, 0, '0, '0, 1'b0, 0);
    endtask

    task automatic mon_port(input bit is_b, input logic v, input logic [W-1:0] dat);
        exp_t e;
        bit   have;
        bit   exp_v;
        e    = '0;
        have = is_b ? (q_b.size() != 0) : (q_a.size() != 0);
        if (have) e = is_b ? q_b[0] : q_a[0];
        exp_v = have && (e.due == cyc);
        check_eq(is_b ? "valid_b" : "valid_a", 64'(v), 64'(exp_v));
        if (exp_v) begin
            if (is_b) void'(q_b.pop_front());
            else      void'(q_a.pop_front());
            check_eq(is_b ? "data_b" : "data_a", 64'(dat), 64'(e.data));
        end else if (!v) begin
            check_eq(is_b ? "hold_b" : "hold_a", 64'(dat), 64'(is_b ? last_b : last_a));
        end
        if (v) begin
            if (is_b) last_b = dat;
            else      last_a = dat;
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        #1;
        if (rst_n) begin
            mon_port(1'b0, rd_valid_a, rd_data_a);
            mon_port(1'b1, rd_valid_b, rd_data_b);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_data_a"},  64'(rd_data_a),  64'(0));
        check_eq({tag, "_valid_a"}, 64'(rd_valid_a), 64'(0));
        check_eq({tag, "_data_b"},  64'(rd_data_b),  64'(0));
        check_eq({tag, "_valid_b"}, 64'(rd_valid_b), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with a read request pending.
        rd_en   = 1'b1;
        rd_addr = 10'd5;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rd_en = 1'b0;
        rst_n = 1'b1;

        op(1'b1, 5, 4'hF, 32'h0000_0055, 1'b0, 0);
        op(1'b0, 0, 4'h0, 32'h0, 1'b1, 5);
        idle(3);

        // Byte-lane writes and an all-lanes-disabled write.
        op(1'b1, 3, 4'hF, 32'hFFFF_FFFF, 1'b0, 0);
        op(1'b1, 3, 4'h1, 32'h0000_0012, 1'b0, 0);
        op(1'b0, 0, 4'h0, 32'h0, 1'b1, 3);
        op(1'b1, 3, 4'h0, 32'hDEAD_BEEF, 1'b0, 0);
        op(1'b0, 0, 4'h0, 32'h0, 1'b1, 3);
        idle(2);

        // Same-address collision, then read-after-write.
        op(1'b1, 7, 4'hF, 32'hAAAA_AAAA, 1'b0, 0);
        op(1'b1, 7, 4'h3, 32'h1122_3344, 1'b1, 7);
        op(1'b0, 0, 4'h0, 32'h0, 1'b1, 7);
        idle(3);

        // Back-to-back streaming reads.
        for (int a = 0; a < 8; a++) op(1'b1, a, 4'hF, 32'h100 + 32'(a), 1'b0, 0);
        for (int a = 0; a < 8; a++) op(1'b0, 0, 4'h0, 32'h0, 1'b1, a);
        idle(3);

        // Extremes of the address range on opposite ports.
        op(1'b1, 1023, 4'hF, 32'hC0FF_EE00, 1'b0, 0);
        op(1'b1, 0,    4'hF, 32'h1234_5678, 1'b1, 1023);
        op(1'b1, 1023, 4'hF, 32'hBADC_0DE5, 1'b1, 0);
        op(1'b0, 0, 4'h0, 32'h0, 1'b1, 1023);
        idle(3);

        // Asynchronous reset with reads in flight.
        op(1'b0, 0, 4'h0, 32'h0, 1'b1, 0);
        op(1'b0, 0, 4'h0, 32'h0, 1'b1, 3);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        rd_en = 1'b0;
        q_a.delete();
        q_b.delete();
        last_a = '0;
        last_b = '0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        op(1'b0, 0, 4'h0, 32'h0, 1'b1, 3);
        op(1'b0, 0, 4'h0, 32'h0, 1'b1, 1023);
        idle(3);

        // Random mixed traffic over a small, fully initialised window.
        for (int a = 0; a < 16; a++) op(1'b1, a, 4'hF, $urandom, 1'b0, 0);
        repeat (60) begin
            op(1'($urandom_range(0, 1)), $urandom_range(0, 15), 4'($urandom_range(0, 15)),
               $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 15));
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
